// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the master and slave sides of this codebase.
package ahb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    XFER = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } slv_state_e;

  localparam logic HRESP_OKAY    = 1'b0;
  localparam logic HRESP_ERROR   = 1'b1;
  localparam logic HTRANS_IDLE   = 1'b0;
  localparam logic HTRANS_ACTIVE = 1'b1;

  // States in which the slave drives HREADYOUT high and can take a new address phase.
  function automatic logic slv_ready_state(input slv_state_e s);
    return (s == IDLE) || (s == XFER) || (s == ERR2);
  endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word storage for ahb_slave_mem: cleared on reset, one write port, one read port
// that forwards same-cycle write data so back-to-back read-after-write sees new data.
module ahb_slave_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite register-memory slave with programmable wait states and two-cycle
// ERROR response for misaligned or out-of-range addresses.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HTRANS,
  input  logic              HWRITE,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int         IDX_W   = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  slv_state_e        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [DATA_W-1:0] r_hrdata;

  logic              w_ready_st, w_accept, w_legal, w_we, w_load;
  logic [IDX_W-1:0]  w_haddr_idx, w_rd_idx;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_ready_st  = slv_ready_state(r_state);
  assign w_accept    = w_ready_st && HSEL && (HTRANS == HTRANS_ACTIVE) && HREADY;
  assign w_haddr_idx = HADDR[IDX_W+1:2];
  assign w_legal     = (HADDR[1:0] == 2'b00) && ((HADDR >> (IDX_W + 2)) == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = XFER;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      ERR1:    w_state_nxt = ERR2;
      default: w_state_nxt = IDLE;
    endcase
    // A new address phase overrides the default return to IDLE.
    if (w_accept) begin
      if (!w_legal) begin
        w_state_nxt = ERR1;
      end else if (WAIT_STATES == 0) begin
        w_state_nxt = XFER;
      end else begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = WS_LOAD;
      end
    end
  end

  assign w_we     = (r_state == XFER) && r_write;
  assign w_rd_idx = (r_state == WAIT) ? r_idx : w_haddr_idx;
  // Read data is captured on the edge that enters XFER: from WAIT, or straight from accept.
  assign w_load   = ((r_state == WAIT) && (r_cnt == 4'd0) && !r_write) ||
                    (w_accept && w_legal && (WAIT_STATES == 0) && !HWRITE);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_hrdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= w_haddr_idx;
        r_write <= HWRITE;
      end
      if (w_load) r_hrdata <= w_ram_rdata;
    end
  end

  ahb_slave_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (HWDATA),
    .i_raddr (w_rd_idx),
    .o_rdata (w_ram_rdata)
  );

  assign HREADYOUT = w_ready_st;
  assign HRESP     = ((r_state == ERR1) || (r_state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = r_hrdata;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one instance with one wait state, one with none.
module tb_ahb_slave_mem;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic        HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        sel1, sel0, which;
  logic [31:0] rdata1, rdata0, obs_rdata;
  logic        rdy1, rdy0, resp1, resp0, obs_rdy, obs_resp;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(1)) u_dut_w1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(rdy1), .HWDATA(HWDATA), .HRDATA(rdata1),
    .HREADYOUT(rdy1), .HRESP(resp1)
  );

  ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) u_dut_w0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(rdy0), .HWDATA(HWDATA), .HRDATA(rdata0),
    .HREADYOUT(rdy0), .HRESP(resp0)
  );

  assign sel1      = which;
  assign sel0      = ~which;
  assign obs_rdata = which ? rdata1 : rdata0;
  assign obs_rdy   = which ? rdy1   : rdy0;
  assign obs_resp  = which ? resp1  : resp0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // One non-pipelined transfer; exp_rd is the HRDATA expected at completion
  // (for errors and writes, the value HRDATA must still hold).
  task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int exp_ws, input logic exp_err,
                         input logic [31:0] exp_rd);
    int n;
    HTRANS = 1'b1; HWRITE = wr; HADDR = addr;
    step();
    HTRANS = 1'b0; HWDATA = wdata;
    if (exp_err) begin
      chk({tag, "_e1_rdy"}, 32'(obs_rdy), 32'd0);
      chk({tag, "_e1_resp"}, 32'(obs_resp), 32'd1);
      step();
      chk({tag, "_e2_rdy"}, 32'(obs_rdy), 32'd1);
      chk({tag, "_e2_resp"}, 32'(obs_resp), 32'd1);
      step();
      chk({tag, "_idle_resp"}, 32'(obs_resp), 32'd0);
      chk({tag, "_rdata_held"}, obs_rdata, exp_rd);
    end else begin
      n = 0;
      while (!obs_rdy && n < 32) begin
        n++;
        step();
      end
      chk({tag, "_ws"}, 32'(n), 32'(exp_ws));
      chk({tag, "_resp"}, 32'(obs_resp), 32'd0);
      chk({tag, "_rdata"}, obs_rdata, exp_rd);
      step();
    end
  endtask

  initial begin
    HRESET = 1'b1; HADDR = '0; HTRANS = 1'b0; HWRITE = 1'b0; HWDATA = '0; which = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    step();
    chk("rst_rdy1", 32'(rdy1), 32'd1);
    chk("rst_resp1", 32'(resp1), 32'd0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'd0);
    chk("rst_rdata0", rdata0, 32'h0);

    // One wait state per data phase
    do_xfer("rd0", 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h0);
    do_xfer("wr8", 1'b1, 32'h8, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
    do_xfer("rd8", 1'b0, 32'h8, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);

    // Illegal addresses: nothing written, HRDATA untouched
    do_xfer("oor_wr", 1'b1, 32'h40, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF);
    do_xfer("mis_rd", 1'b0, 32'h2, 32'h0, 0, 1'b1, 32'hDEAD_BEEF);
    do_xfer("mis_wr", 1'b1, 32'h2, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF);
    do_xfer("hi_wr", 1'b1, 32'h8000_0008, 32'h0BAD_0BAD, 0, 1'b1, 32'hDEAD_BEEF);
    do_xfer("rd0_after_err", 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h0);
    do_xfer("rd8_after_err", 1'b0, 32'h8, 32'h0, 1, 1'b0, 32'hDEAD_BEEF);

    // Master BUSY: selected but HTRANS=0 for three cycles
    HTRANS = 1'b0; HWRITE = 1'b1; HADDR = 32'hC; HWDATA = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_rdy", 32'(rdy1), 32'd1);
      chk("busy_resp", 32'(resp1), 32'd0);
    end
    do_xfer("rdC_after_busy", 1'b0, 32'hC, 32'h0, 1, 1'b0, 32'h0);

    // Zero wait states: pipelined write then read of the same word
    which = 1'b0;
    HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 32'h4;
    step();
    HWDATA = 32'h1234_5678; HTRANS = 1'b1; HWRITE = 1'b0; HADDR = 32'h4;
    chk("fwd_wr_rdy", 32'(rdy0), 32'd1);
    step();
    HTRANS = 1'b0;
    chk("fwd_rd_rdy", 32'(rdy0), 32'd1);
    chk("fwd_rd_resp", 32'(resp0), 32'd0);
    chk("fwd_rd_data", rdata0, 32'h1234_5678);
    step();
    do_xfer("rd4_w0", 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h1234_5678);

    // Zero wait states: pipelined read then write of the same word returns old data
    HTRANS = 1'b1; HWRITE = 1'b0; HADDR = 32'h4;
    step();
    HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 32'h4;
    chk("war_rd_data", rdata0, 32'h1234_5678);
    step();
    HTRANS = 1'b0; HWDATA = 32'h0000_0055;
    chk("war_wr_rdy", 32'(rdy0), 32'd1);
    chk("war_rdata_held", rdata0, 32'h1234_5678);
    step();
    do_xfer("rd4_war", 1'b0, 32'h4, 32'h0, 0, 1'b0, 32'h0000_0055);

    // Reset during the wait state of a write
    which = 1'b1;
    HTRANS = 1'b1; HWRITE = 1'b1; HADDR = 32'hC;
    step();
    HTRANS = 1'b0; HWDATA = 32'hAAAA_5555;
    chk("rstw_wait_rdy", 32'(rdy1), 32'd0);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    chk("rstw_rdy", 32'(rdy1), 32'd1);
    chk("rstw_resp", 32'(resp1), 32'd0);
    chk("rstw_rdata", rdata1, 32'h0);
    step();
    chk("rstw_idle_rdy", 32'(rdy1), 32'd1);
    do_xfer("rdC_after_rst", 1'b0, 32'hC, 32'h0, 1, 1'b0, 32'h0);
    do_xfer("rd8_after_rst", 1'b0, 32'h8, 32'h0, 1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
